multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multicycle control unit that replaces the single-cycle main decoder when the datapath moves to a shared instruction/data memory and a multi-step execute sequence. It holds a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback, and waits on a memory-ready handshake. It emits datapath enables and mux selects, raises a sticky trap on unsupported opcodes, and keeps a retired-instruction counter. It sits between the instruction register's opcode field and the multicycle datapath; ALU function decoding stays in the separate ALU decoder.

## Interface
- EN_BNE, 1, 1 = decode opcode 000101 (bne); 0 = bne traps
- EN_ORI, 1, 1 = decode opcode 001101 (ori, alu_op 11); 0 = ori traps
- CNT_W, 32, width of retired counter (≥2)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op_code  in  6  instruction[31:26] from IR
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req / mem_write / iord  out  1  memory request, write strobe, address select (1 = ALUOut)
- ir_write / pc_write / pc_en  out  1  IR load, unconditional PC write, final PC enable
- reg_write / reg_dst / mem_to_reg  out  1  register file controls
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 signext imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 or
- pc_src  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- trap  out  1  sticky unsupported-opcode flag
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired  out  CNT_W  retired-instruction count

## Operation
- States (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BEQ, BNE, IEXEC, IWB, JUMP, TRAP. All outputs not listed are 0.
- FETCH: mem_req=1, alu_src_b=01; ir_write=pc_write=mem_ready. Go to DECODE when mem_ready, else stay.
- DECODE: alu_src_b=11. By op_code: 100011/101011→MEMADR; 000000→EXEC; 000100→BEQ; 000101→BNE if EN_BNE; 001000→IEXEC; 001101→IEXEC if EN_ORI; 000010→JUMP; anything else→TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10; lw→MEMRD, sw→MEMWR (opcode re-read; IR is stable).
- MEMRD: mem_req=1, iord=1; →MEMWB on mem_ready, else stay.
- MEMWB: reg_write=1, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1; →FETCH on mem_ready, else stay.
- EXEC: alu_src_a=1, alu_op=10 → ALUWB. ALUWB: reg_write=1, reg_dst=1 → FETCH.
- BEQ/BNE: alu_src_a=1, alu_op=01, pc_src=01 → FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00 (addi) or 11 (ori) → IWB. IWB: reg_write=1 → FETCH.
- JUMP: pc_src=10, pc_write=1 → FETCH.
- TRAP: trap=1, no enables, no memory request; held until reset.
- pc_en = pc_write | (state==BEQ & alu_zero) | (state==BNE & ~alu_zero), combinational.
- instr_done=1 in MEMWB, ALUWB, BEQ, BNE, IWB, JUMP, and in MEMWR when mem_ready. retired increments on those cycles and wraps modulo 2^CNT_W.

## Timing
- Reset asserted: state=FETCH, retired=0, trap=0. mem_req, mem_write, ir_write, pc_write, pc_en, reg_write and instr_done are forced 0 while reset is high. First fetch request occurs in the first cycle after deassertion.
- Zero-wait latency in cycles (FETCH to return to FETCH): R 4, lw 5, sw 4, addi/ori 4, beq/bne 3, j 3. Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
- mem_req stays asserted and address select is stable until the mem_ready cycle. mem_ready is ignored in all other states.
- Selects are Moore outputs (state only). Only pc_en depends on alu_zero, and ir_write/pc_write/mem_write-completion depend on mem_ready, in the same cycle.
- Reset mid-instruction: aborts immediately. No partial writeback follows.

## Test plan
- Reset, mem_ready=1, op 000000 → states FETCH,DECODE,EXEC,ALUWB; reg_write=reg_dst=1 in cycle 4; retired=1.
- lw (100011) with mem_ready low for 2 cycles in MEMRD → 7 cycles total; mem_to_reg=1 and reg_write=1 only in MEMWB.
- beq with alu_zero=1 → pc_en=1 in BEQ; with alu_zero=0 → pc_en=0; bne is the inverse; 3 cycles each.
- EN_BNE=0, op 000101 → TRAP after DECODE; trap stays 1 and mem_req stays 0 for 10 cycles; reset clears it.
- CNT_W=4: retire 17 j instructions → retired=1 after wrap; instr_done pulses 17 times.
- Reset asserted in MEMWR while mem_ready=0 → mem_write drops asynchronously; FETCH follows deassertion.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle main control unit: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback with a memory-ready handshake.
module multicycle_controller #(
    parameter bit EN_BNE = 1'b1,
    parameter bit EN_ORI = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op_code,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_en,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             trap,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
        BEQ, BNE, IEXEC, IWB, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_req_s, mem_write_s, ir_write_s, pc_write_s;
    logic             reg_write_s, done_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op_code)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_BNE:       state_d = EN_BNE ? BNE : TRAP;
                    OP_ADDI:      state_d = IEXEC;
                    OP_ORI:       state_d = EN_ORI ? IEXEC : TRAP;
                    OP_J:         state_d = JUMP;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: state_d = (op_code == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            IEXEC:  state_d = IWB;
            TRAP:   state_d = TRAP;
            MEMWB, ALUWB, BEQ, BNE, IWB, JUMP: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        iord        = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_src      = 2'b00;
        trap        = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_req_s = 1'b1;
                iord      = 1'b1;
            end
            MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                done_s      = 1'b1;
            end
            MEMWR: begin
                mem_req_s   = 1'b1;
                iord        = 1'b1;
                mem_write_s = 1'b1;
                done_s      = mem_ready;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
                done_s      = 1'b1;
            end
            BEQ, BNE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                done_s    = 1'b1;
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_code == OP_ORI) ? 2'b11 : 2'b00;
            end
            IWB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write_s = 1'b1;
                done_s     = 1'b1;
            end
            TRAP:    trap = 1'b1;
            default: ;
        endcase
    end

    // Side-effecting strobes are gated by reset so an abort never leaks a write
    assign mem_req    = mem_req_s & ~reset;
    assign mem_write  = mem_write_s & ~reset;
    assign ir_write   = ir_write_s & ~reset;
    assign pc_write   = pc_write_s & ~reset;
    assign reg_write  = reg_write_s & ~reset;
    assign instr_done = done_s & ~reset;
    assign pc_en      = ~reset & (pc_write_s | ((state_q == BEQ) & alu_zero)
                                             | ((state_q == BNE) & ~alu_zero));

    assign retired_d = done_s ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: cycle-by-cycle vector table on a default instance, plus
// trap, counter-wrap and mid-write reset sequences.
module tb_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst = 1'b1, zero = 1'b0, rdy = 1'b1;
    logic [5:0]  op = '0;
    logic        mem_req, mem_write, iord, ir_write, pc_write, pc_en;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, trap, done;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [31:0] retired;

    multicycle_controller dut (
        .clk(clk), .reset(rst), .op_code(op), .alu_zero(zero), .mem_ready(rdy),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .trap(trap), .instr_done(done),
        .retired(retired)
    );

    // reduced instance: bne/ori disabled, 4-bit counter
    logic        b_rst = 1'b1, b_zero = 1'b0, b_rdy = 1'b1;
    logic [5:0]  b_op = '0;
    logic        b_mem_req, b_mem_write, b_iord, b_ir_write, b_pc_write, b_pc_en;
    logic        b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a, b_trap, b_done;
    logic [1:0]  b_alu_src_b, b_alu_op, b_pc_src;
    logic [3:0]  b_retired;

    multicycle_controller #(.EN_BNE(1'b0), .EN_ORI(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(b_rst), .op_code(b_op), .alu_zero(b_zero), .mem_ready(b_rdy),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .iord(b_iord), .ir_write(b_ir_write),
        .pc_write(b_pc_write), .pc_en(b_pc_en), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_op(b_alu_op), .pc_src(b_pc_src), .trap(b_trap), .instr_done(b_done),
        .retired(b_retired)
    );

    // {mem_req,mem_write,iord,ir_write,pc_write,pc_en,reg_write,reg_dst,
    //  mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_src,trap,instr_done}
    localparam logic [17:0] O_RST    = 18'b0_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] O_FETCHR = 18'b1_0_0_1_1_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] O_FETCHW = 18'b1_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] O_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] O_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] O_ALUWB  = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_0_1;
    localparam logic [17:0] O_MADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] O_MRD    = 18'b1_0_1_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_MWB    = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
    localparam logic [17:0] O_MWRW   = 18'b1_1_1_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_MWRD   = 18'b1_1_1_0_0_0_0_0_0_0_00_00_00_0_1;
    localparam logic [17:0] O_BR_T   = 18'b0_0_0_0_0_1_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] O_BR_N   = 18'b0_0_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] O_IADD   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] O_IOR    = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
    localparam logic [17:0] O_IWB    = 18'b0_0_0_0_0_0_1_0_0_0_00_00_00_0_1;
    localparam logic [17:0] O_JUMP   = 18'b0_0_0_0_1_1_0_0_0_0_00_00_10_0_1;
    localparam logic [17:0] O_TRAP   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [17:0] exp;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic z,
                       input logic m, input logic [17:0] e, input logic [31:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.rdy = m; v.exp = e; v.ret = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] obs();
        return {mem_req, mem_write, iord, ir_write, pc_write, pc_en, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, trap, done};
    endfunction

    int pulses;

    initial begin
        // reset, R-type
        add(1, 6'b000000, 0, 1, O_RST,    0);
        add(0, 6'b000000, 0, 1, O_FETCHR, 0);
        add(0, 6'b000000, 0, 1, O_DEC,    0);
        add(0, 6'b000000, 0, 1, O_EXEC,   0);
        add(0, 6'b000000, 0, 1, O_ALUWB,  0);
        // lw with two wait cycles in MEMRD
        add(0, 6'b100011, 0, 1, O_FETCHR, 1);
        add(0, 6'b100011, 0, 1, O_DEC,    1);
        add(0, 6'b100011, 0, 1, O_MADR,   1);
        add(0, 6'b100011, 0, 0, O_MRD,    1);
        add(0, 6'b100011, 0, 0, O_MRD,    1);
        add(0, 6'b100011, 0, 1, O_MRD,    1);
        add(0, 6'b100011, 0, 1, O_MWB,    1);
        // sw with a fetch wait and a write wait
        add(0, 6'b101011, 0, 0, O_FETCHW, 2);
        add(0, 6'b101011, 0, 1, O_FETCHR, 2);
        add(0, 6'b101011, 0, 1, O_DEC,    2);
        add(0, 6'b101011, 0, 1, O_MADR,   2);
        add(0, 6'b101011, 0, 0, O_MWRW,   2);
        add(0, 6'b101011, 0, 1, O_MWRD,   2);
        // addi, ori
        add(0, 6'b001000, 0, 1, O_FETCHR, 3);
        add(0, 6'b001000, 0, 1, O_DEC,    3);
        add(0, 6'b001000, 0, 1, O_IADD,   3);
        add(0, 6'b001000, 0, 1, O_IWB,    3);
        add(0, 6'b001101, 0, 1, O_FETCHR, 4);
        add(0, 6'b001101, 0, 1, O_DEC,    4);
        add(0, 6'b001101, 0, 1, O_IOR,    4);
        add(0, 6'b001101, 0, 1, O_IWB,    4);
        // beq taken / not taken, bne taken / not taken
        add(0, 6'b000100, 1, 1, O_FETCHR, 5);
        add(0, 6'b000100, 1, 1, O_DEC,    5);
        add(0, 6'b000100, 1, 1, O_BR_T,   5);
        add(0, 6'b000100, 0, 1, O_FETCHR, 6);
        add(0, 6'b000100, 0, 1, O_DEC,    6);
        add(0, 6'b000100, 0, 1, O_BR_N,   6);
        add(0, 6'b000101, 0, 1, O_FETCHR, 7);
        add(0, 6'b000101, 0, 1, O_DEC,    7);
        add(0, 6'b000101, 0, 1, O_BR_T,   7);
        add(0, 6'b000101, 1, 1, O_FETCHR, 8);
        add(0, 6'b000101, 1, 1, O_DEC,    8);
        add(0, 6'b000101, 1, 1, O_BR_N,   8);
        // j
        add(0, 6'b000010, 0, 1, O_FETCHR, 9);
        add(0, 6'b000010, 0, 1, O_DEC,    9);
        add(0, 6'b000010, 0, 1, O_JUMP,   9);
        // illegal opcode traps, held until reset
        add(0, 6'b111111, 0, 1, O_FETCHR, 10);
        add(0, 6'b111111, 0, 1, O_DEC,    10);
        add(0, 6'b111111, 0, 1, O_TRAP,   10);
        add(0, 6'b111111, 1, 1, O_TRAP,   10);
        add(0, 6'b000000, 0, 1, O_TRAP,   10);
        add(1, 6'b000000, 0, 1, O_RST,    0);
        add(0, 6'b000000, 0, 1, O_FETCHR, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; op = vecs[i].op; zero = vecs[i].zero; rdy = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_outputs", i), {14'd0, obs()}, {14'd0, vecs[i].exp});
            chk($sformatf("vec%0d_retired", i), retired, vecs[i].ret);
        end

        // reset during a stalled store: write strobe drops without a clock edge
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; op = 6'b101011; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rdy = 1'b0;
        #1 chk("memwr_before_reset", {30'd0, mem_write, mem_req}, 32'd3);
        #2 rst = 1'b1;
        #1 chk("memwr_async_abort", {29'd0, mem_write, mem_req, reg_write}, 32'd0);
        @(negedge clk); rst = 1'b0; rdy = 1'b1;
        #1 chk("fetch_after_abort", {30'd0, mem_req, ir_write}, 32'd3);
        @(negedge clk);
        #1 chk("decode_after_abort", {30'd0, alu_src_b}, 32'd3);

        // bne disabled: trap is sticky, no memory traffic
        @(negedge clk); b_rst = 1'b1;
        @(negedge clk); b_rst = 1'b0; b_op = 6'b000101; b_rdy = 1'b1;
        @(negedge clk);
        #1 chk("bne_dis_decode_trap", {31'd0, b_trap}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); b_rdy = c[0];
            #1 chk($sformatf("bne_dis_hold%0d", c), {30'd0, b_trap, b_mem_req}, 32'd2);
        end
        @(negedge clk); b_rst = 1'b1;
        #1 chk("trap_cleared", {31'd0, b_trap}, 32'd0);
        // ori disabled
        @(negedge clk); b_rst = 1'b0; b_op = 6'b001101; b_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("ori_dis_trap", {31'd0, b_trap}, 32'd1);

        // 4-bit counter wraps after 17 jumps
        @(negedge clk); b_rst = 1'b1;
        @(negedge clk); b_rst = 1'b0; b_op = 6'b000010;
        pulses = 0;
        #1 if (b_done) pulses++;
        for (int c = 1; c < 51; c++) begin
            @(negedge clk);
            #1 if (b_done) pulses++;
        end
        chk("done_pulses", pulses, 32'd17);
        @(negedge clk);
        #1 chk("retired_wrap", {28'd0, b_retired}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
